// File: rtl/flag_branch_unit.sv
// Condition flag register and decode-stage branch resolver.
// EX-stage flag writes are bypassed into same-cycle B.cond resolution.
module flag_branch_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  input  logic             ex_valid,
  input  logic             set_flags,
  input  logic             br_valid,
  input  logic [1:0]       br_kind,
  input  logic [3:0]       br_cond,
  input  logic [WIDTH-1:0] cbz_operand,
  input  logic             stall,
  input  logic             flush,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             branch_taken,
  output logic             branch_done
);

  localparam int G = WIDTH / 16;

  logic [G-1:0] res_grp;
  logic [G-1:0] cbz_grp;

  // Two-level zero detect: per-16-bit group, then across groups.
  genvar g;
  generate
    for (g = 0; g < G; g++) begin : g_zero
      assign res_grp[g] = &(~alu_result[g*16 +: 16]);
      assign cbz_grp[g] = &(~cbz_operand[g*16 +: 16]);
    end
  endgenerate

  logic new_n, new_z, new_c, new_v;
  logic cbz_zero;
  logic bypass, flag_wr;
  logic eff_n, eff_z, eff_c, eff_v;
  logic cond_ok, taken, done_d;

  assign new_n    = alu_result[WIDTH-1];
  assign new_z    = &res_grp;
  assign new_c    = alu_carry;
  assign new_v    = alu_overflow;
  assign cbz_zero = &cbz_grp;

  assign bypass  = ex_valid & set_flags;
  assign flag_wr = bypass & ~stall;

  assign eff_n = bypass ? new_n : flag_n;
  assign eff_z = bypass ? new_z : flag_z;
  assign eff_c = bypass ? new_c : flag_c;
  assign eff_v = bypass ? new_v : flag_v;

  always_comb begin
    cond_ok = 1'b0;
    case (br_cond)
      4'b0000: cond_ok = eff_z;
      4'b0001: cond_ok = ~eff_z;
      4'b1010: cond_ok = (eff_n == eff_v);
      4'b1011: cond_ok = (eff_n != eff_v);
      4'b1100: cond_ok = ~eff_z & (eff_n == eff_v);
      4'b1101: cond_ok = eff_z | (eff_n != eff_v);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (br_kind)
      2'b01:   taken = 1'b1;
      2'b10:   taken = cbz_zero;
      2'b11:   taken = cond_ok;
      default: taken = 1'b0;
    endcase
  end

  assign done_d = br_valid & (br_kind != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      flag_n       <= 1'b0;
      flag_z       <= 1'b0;
      flag_c       <= 1'b0;
      flag_v       <= 1'b0;
      branch_taken <= 1'b0;
      branch_done  <= 1'b0;
    end else begin
      if (flag_wr) begin
        flag_n <= new_n;
        flag_z <= new_z;
        flag_c <= new_c;
        flag_v <= new_v;
      end
      if (flush) begin
        branch_done  <= 1'b0;
        branch_taken <= 1'b0;
      end else if (!stall) begin
        branch_done  <= done_d;
        branch_taken <= done_d & taken;
      end
    end
  end

  // eff_c feeds no implemented condition but keeps the bypass set uniform.
  logic unused_c;
  assign unused_c = eff_c;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Scoreboard bench for flag_branch_unit with a behavioural flag/branch model.
// Driver pushes expected state per cycle; monitor pops and compares.
module tb_flag_branch_unit;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] alu_result = '0;
  logic         alu_carry = 1'b0;
  logic         alu_overflow = 1'b0;
  logic         ex_valid = 1'b0;
  logic         set_flags = 1'b0;
  logic         br_valid = 1'b0;
  logic [1:0]   br_kind = 2'b00;
  logic [3:0]   br_cond = 4'b0000;
  logic [W-1:0] cbz_operand = '0;
  logic         stall = 1'b0;
  logic         flush = 1'b0;
  logic         flag_n, flag_z, flag_c, flag_v;
  logic         branch_taken, branch_done;

  always #5 clk = ~clk;

  flag_branch_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow), .ex_valid(ex_valid),
    .set_flags(set_flags), .br_valid(br_valid),
    .br_kind(br_kind), .br_cond(br_cond),
    .cbz_operand(cbz_operand), .stall(stall), .flush(flush),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c),
    .flag_v(flag_v), .branch_taken(branch_taken),
    .branch_done(branch_done)
  );

  typedef struct packed {
    logic n, z, c, v, bt, bd;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passed = 0;
  int cyc = 0;

  bit mn, mz, mc, mv, mbt, mbd;

  function automatic bit cond_true(logic [3:0] c, bit n, bit z, bit v);
    case (c)
      4'd0:    return z;
      4'd1:    return !z;
      4'd10:   return n == v;
      4'd11:   return n != v;
      4'd12:   return !z && (n == v);
      4'd13:   return z || (n != v);
      4'd14:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step();
    bit use_new, en, ez, ev, tk;
    exp_t e;
    if (reset) begin
      {mn, mz, mc, mv, mbt, mbd} = '0;
    end else begin
      use_new = ex_valid && set_flags;
      en = use_new ? alu_result[W-1] : mn;
      ez = use_new ? (alu_result == 0) : mz;
      ev = use_new ? alu_overflow : mv;
      case (br_kind)
        2'd1:    tk = 1'b1;
        2'd2:    tk = (cbz_operand == 0);
        2'd3:    tk = cond_true(br_cond, en, ez, ev);
        default: tk = 1'b0;
      endcase
      if (flush) begin
        mbd = 1'b0;
        mbt = 1'b0;
      end else if (!stall) begin
        mbd = br_valid && (br_kind != 2'd0);
        mbt = mbd && tk;
      end
      if (use_new && !stall) begin
        mn = alu_result[W-1];
        mz = (alu_result == 0);
        mc = alu_carry;
        mv = alu_overflow;
      end
    end
    e.n = mn; e.z = mz; e.c = mc; e.v = mv;
    e.bt = mbt; e.bd = mbd;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    ex_valid = 0; set_flags = 0; alu_result = '0;
    alu_carry = 0; alu_overflow = 0;
    br_valid = 0; br_kind = 0; br_cond = 0;
    cbz_operand = '0; stall = 0; flush = 0;
  endtask

  task automatic setf(logic [W-1:0] r, bit c, bit v);
    ex_valid = 1; set_flags = 1;
    alu_result = r; alu_carry = c; alu_overflow = v;
  endtask

  task automatic br(logic [1:0] k, logic [3:0] c);
    br_valid = 1; br_kind = k; br_cond = c;
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] r;
    case ($urandom_range(3))
      0:       r = '0;
      1:       r = 64'd1 << $urandom_range(W-1);
      2:       r = {$urandom, $urandom};
      default: r = {1'b1, 31'($urandom), $urandom};
    endcase
    return r;
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({flag_n, flag_z, flag_c, flag_v} == {e.n, e.z, e.c, e.v})
          passed++;
        else
          $display("FAIL flags cyc=%0d got nzcv=%b%b%b%b want %b%b%b%b",
                   cyc, flag_n, flag_z, flag_c, flag_v,
                   e.n, e.z, e.c, e.v);
        checks++;
        if ({branch_taken, branch_done} == {e.bt, e.bd})
          passed++;
        else
          $display("FAIL branch cyc=%0d got taken/done=%b%b want %b%b",
                   cyc, branch_taken, branch_done, e.bt, e.bd);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    reset = 1;
    setf('0, 0, 0);
    @(negedge clk);
    step(); step();
    reset = 0;
    step();
    idle(); step();

    setf('0, 1, 0); step();
    for (int k = 0; k < W; k++) begin
      setf(64'd1 << k, k[0], k[1]);
      step();
    end
    setf(64'h8000_0000_0000_0000, 0, 1); step();

    idle(); setf(64'd1, 0, 0); step();
    idle(); setf('0, 0, 0); br(2'd3, 4'd0); step();
    idle(); step();

    setf(64'h8000_0000_0000_0000, 0, 0); step();
    idle(); br(2'd3, 4'd11); step();
    br(2'd3, 4'd10); step();
    idle(); setf(64'h8000_0000_0000_0000, 0, 1); step();
    idle(); br(2'd3, 4'd10); step();
    idle(); setf('0, 0, 0); step();
    idle(); br(2'd3, 4'd12); step();
    br(2'd3, 4'd13); step();
    br(2'd3, 4'd6); step();

    idle(); br(2'd2, 4'd0); cbz_operand = '0; step();
    cbz_operand = 64'h0000_0001_0000_0000; step();
    br(2'd1, 4'd0); step();
    br(2'd0, 4'd0); step();

    idle(); setf(64'd5, 1, 1); step();
    idle(); br(2'd1, 4'd0); step();
    idle(); stall = 1; setf('0, 0, 0); step(); step();
    stall = 0; step();
    idle(); stall = 1; flush = 1; br(2'd1, 4'd0); step();
    idle(); step();

    for (int i = 0; i < 600; i++) begin
      reset        = ($urandom_range(39) == 0);
      ex_valid     = $urandom_range(1);
      set_flags    = $urandom_range(1);
      alu_result   = pick();
      alu_carry    = $urandom_range(1);
      alu_overflow = $urandom_range(1);
      br_valid     = $urandom_range(3) != 0;
      br_kind      = 2'($urandom_range(3));
      br_cond      = 4'($urandom_range(15));
      cbz_operand  = pick();
      stall        = ($urandom_range(4) == 0);
      flush        = ($urandom_range(7) == 0);
      step();
    end
    reset = 0;
    idle();
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain got %0d pending want 0", q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
